// File: rtl/spram16_ctl.sv
// Byte-addressed, little-endian controller over a 16-bit single-port word array.
// Unaligned 16-bit accesses take two word cycles; optional zero-fill after reset.
module spram16_ctl #(
  parameter int ASZ        = 17,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic           we,
  input  logic           sz,
  input  logic [ASZ-1:0] ai,
  input  logic [15:0]    vi,
  output logic [15:0]    vo,
  output logic           ack,
  output logic           busy
);

  // Handshake: req/we/sz/ai/vi are sampled at a rising edge only while busy=0;
  // every accepted request yields exactly one ack pulse, and vo is valid with it.

  localparam int WA    = ASZ - 1;
  localparam int WORDS = 1 << WA;
  localparam logic [WA-1:0] W_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_SPLIT, S_CLR} state_t;

  state_t          state_q, state_d;
  logic [WA-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [WA-1:0]   wa_q, wa_d;
  logic [7:0]      vhi_q, vhi_d;
  logic [7:0]      lo_q, lo_d;
  logic [15:0]     vo_q, vo_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;

  logic [15:0]     mem [WORDS];
  logic [1:0]      mem_we;
  logic [WA-1:0]   mem_wa, mem_ra;
  logic [15:0]     mem_wd;
  logic [15:0]     rd_word;

  assign rd_word = mem[mem_ra];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    wa_d    = wa_q;
    vhi_d   = vhi_q;
    lo_d    = lo_q;
    vo_d    = vo_q;
    ack_d   = 1'b0;
    mem_we  = 2'b00;
    mem_wa  = ai[ASZ-1:1];
    mem_ra  = ai[ASZ-1:1];
    mem_wd  = vi;

    case (state_q)
      S_CLR: begin
        mem_we = 2'b11;
        mem_wa = cnt_q;
        mem_wd = 16'h0000;
        cnt_d  = cnt_q + W_ONE;
        if (cnt_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (req) begin
          if (sz && ai[0]) begin
            // First half of an unaligned word: high lane of the lower word.
            // The second word index is precomputed so it wraps at the top.
            we_d    = we;
            wa_d    = ai[ASZ-1:1] + W_ONE;
            vhi_d   = vi[15:8];
            state_d = S_SPLIT;
            if (we) begin
              mem_we = 2'b10;
              mem_wd = {vi[7:0], 8'h00};
            end else begin
              lo_d = rd_word[15:8];
            end
          end else begin
            ack_d = 1'b1;
            if (we) begin
              mem_we = sz ? 2'b11 : (ai[0] ? 2'b10 : 2'b01);
              mem_wd = sz ? vi : {vi[7:0], vi[7:0]};
            end else begin
              vo_d = sz ? rd_word : {8'h00, (ai[0] ? rd_word[15:8] : rd_word[7:0])};
            end
          end
        end
      end
      S_SPLIT: begin
        mem_wa  = wa_q;
        mem_ra  = wa_q;
        ack_d   = 1'b1;
        state_d = S_IDLE;
        if (we_q) begin
          mem_we = 2'b01;
          mem_wd = {8'h00, vhi_q};
        end else begin
          vo_d = {rd_word[7:0], lo_q};
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    // A reset edge aborts whatever access was in flight.
    if (!rst) mem_we = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= CLR_ON_RST ? S_CLR : S_IDLE;
      busy_q  <= CLR_ON_RST;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      vhi_q   <= 8'h00;
      lo_q    <= 8'h00;
      vo_q    <= 16'h0000;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      vhi_q   <= vhi_d;
      lo_q    <= lo_d;
      vo_q    <= vo_d;
      ack_q   <= ack_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we[0]) mem[mem_wa][7:0]  <= mem_wd[7:0];
    if (mem_we[1]) mem[mem_wa][15:8] <= mem_wd[15:8];
  end

  assign vo   = vo_q;
  assign ack  = ack_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_spram16_ctl.sv
// Bench for spram16_ctl: byte-array reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_spram16_ctl;

  localparam int ASZ  = 10;
  localparam int SIZE = 1 << ASZ;
  localparam int N    = SIZE / 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req = 1'b0;
  logic           we  = 1'b0;
  logic           sz  = 1'b0;
  logic [ASZ-1:0] ai  = '0;
  logic [15:0]    vi  = 16'h0000;
  logic [15:0]    vo;
  logic           ack;
  logic           busy;

  spram16_ctl #(.ASZ(ASZ), .CLR_ON_RST(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .sz(sz),
    .ai(ai), .vi(vi), .vo(vo), .ack(ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: byte array plus expected outputs after the next edge.
  logic [7:0]  m_mem [SIZE];
  logic        e_ack, e_busy;
  logic [15:0] e_vo;
  logic [15:0] exp_q [$];
  int          fill_left = 0;
  bit          pend = 0, pend_rd = 0, m_valid = 0;
  int          n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    logic [ASZ-1:0] a1;
    logic [15:0]    rdv;
    if (!rst) begin
      e_ack = 1'b0; e_vo = 16'h0000; e_busy = 1'b1;
      fill_left = N; pend = 0; exp_q.delete();
      for (int i = 0; i < SIZE; i++) m_mem[i] = 8'h00;
      m_valid = 1;
    end else if (fill_left > 0) begin
      fill_left--;
      e_busy = (fill_left != 0);
      e_ack  = 1'b0;
    end else if (pend) begin
      pend = 0; e_ack = 1'b1; e_busy = 1'b0;
      rdv = exp_q.pop_front();
      if (pend_rd) e_vo = rdv;
    end else if (req) begin
      a1 = ai + 1'b1;
      if (we) begin
        m_mem[ai] = vi[7:0];
        if (sz) m_mem[a1] = vi[15:8];
      end
      rdv = sz ? {m_mem[a1], m_mem[ai]} : {8'h00, m_mem[ai]};
      if (sz && ai[0]) begin
        pend = 1; pend_rd = !we; exp_q.push_back(rdv);
        e_busy = 1'b1; e_ack = 1'b0;
      end else begin
        e_ack = 1'b1; e_busy = 1'b0;
        if (!we) e_vo = rdv;
      end
    end else begin
      e_ack = 1'b0; e_busy = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_ack", {15'h0, ack}, {15'h0, e_ack});
      check("cyc_busy", {15'h0, busy}, {15'h0, e_busy});
      check("cyc_vo", vo, e_vo);
    end
    model_step();
  end

  task automatic wait_idle();
    int k = 0;
    while (e_busy && k < 4 * N) begin
      @(posedge clk); #1; k++;
    end
    if (e_busy) begin
      n_checks++;
      $display("FAIL wait_idle: busy never cleared");
    end
  endtask

  task automatic access(input bit w, input bit s, input logic [ASZ-1:0] a, input logic [15:0] v);
    wait_idle();
    we = w; sz = s; ai = a; vi = v; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic rd_lit(input bit s, input logic [ASZ-1:0] a, input logic [15:0] lit, input string nm);
    int k = 0;
    access(1'b0, s, a, 16'h0000);
    while (!ack && k < 4) begin
      @(posedge clk); #1; k++;
    end
    if (!ack) begin
      n_checks++;
      $display("FAIL %s: no ack within 4 cycles", nm);
    end else check(nm, vo, lit);
  endtask

  task automatic do_reset(input int hold);
    int cnt = 0;
    rst = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    check("rst_ack", {15'h0, ack}, 16'h0000);
    check("rst_busy", {15'h0, busy}, 16'h0001);
    check("rst_vo", vo, 16'h0000);
    rst = 1'b1;
    while (busy && cnt < N + 16) begin
      @(posedge clk); #1; cnt++;
    end
    check("fill_cycles", 16'(cnt), 16'(N));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    bit busy_seen;

    // Fill after reset; then refill wipes a non-zero top word.
    do_reset(2);
    access(1'b1, 1'b1, ASZ'(SIZE - 2), 16'hDEAD);
    rd_lit(1'b1, ASZ'(SIZE - 2), 16'hDEAD, "top_preload");
    do_reset(1);
    rd_lit(1'b1, ASZ'(SIZE - 2), 16'h0000, "top_after_fill");

    // Byte lanes.
    access(1'b1, 1'b0, ASZ'(5), 16'h00A5);
    access(1'b1, 1'b0, ASZ'(4), 16'h003C);
    rd_lit(1'b1, ASZ'(4), 16'hA53C, "lanes_rd16");
    rd_lit(1'b0, ASZ'(5), 16'h00A5, "lanes_rd8");

    // Unaligned split write: busy one cycle, ack two cycles after acceptance.
    access(1'b1, 1'b1, ASZ'(12'h101), 16'hBEEF);
    check("split_ack0", {15'h0, ack}, 16'h0000);
    check("split_busy1", {15'h0, busy}, 16'h0001);
    @(posedge clk); #1;
    check("split_ack1", {15'h0, ack}, 16'h0001);
    check("split_busy0", {15'h0, busy}, 16'h0000);
    rd_lit(1'b0, ASZ'(12'h101), 16'h00EF, "split_b101");
    rd_lit(1'b0, ASZ'(12'h102), 16'h00BE, "split_b102");
    rd_lit(1'b0, ASZ'(12'h100), 16'h0000, "split_b100");
    rd_lit(1'b0, ASZ'(12'h103), 16'h0000, "split_b103");
    rd_lit(1'b1, ASZ'(12'h101), 16'hBEEF, "split_rd16");

    // Wrap-around at the top byte.
    access(1'b1, 1'b1, ASZ'(SIZE - 1), 16'h1234);
    rd_lit(1'b0, ASZ'(SIZE - 1), 16'h0034, "wrap_top");
    rd_lit(1'b0, ASZ'(0), 16'h0012, "wrap_zero");
    rd_lit(1'b1, ASZ'(SIZE - 1), 16'h1234, "wrap_rd16");

    // Back-to-back aligned writes with req held.
    wait_idle();
    acks = 0; busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; sz = 1'b1; ai = ASZ'(2 * i); vi = 16'h1111 * 16'(i + 1); req = 1'b1;
      @(posedge clk); #1;
      acks += int'(ack); busy_seen |= busy;
    end
    req = 1'b0;
    @(posedge clk); #1;
    acks += int'(ack); busy_seen |= busy;
    check("b2b_acks", 16'(acks), 16'd4);
    check("b2b_busy", {15'h0, busy_seen}, 16'h0000);
    for (int i = 0; i < 4; i++)
      rd_lit(1'b1, ASZ'(2 * i), 16'h1111 * 16'(i + 1), "b2b_rd");

    // Request during SPLIT is ignored.
    access(1'b1, 1'b1, ASZ'(12'h011), 16'h5A5A);
    we = 1'b1; sz = 1'b0; ai = ASZ'(12'h040); vi = 16'h00FF; req = 1'b1;
    @(posedge clk); #1;
    acks = int'(ack);
    req = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      acks += int'(ack);
    end
    check("split_ignore_acks", 16'(acks), 16'd1);
    rd_lit(1'b0, ASZ'(12'h040), 16'h0000, "split_ignore_data");
    rd_lit(1'b1, ASZ'(12'h011), 16'h5A5A, "split_ignore_rd16");

    // Reset during the SPLIT cycle aborts the write.
    access(1'b1, 1'b1, ASZ'(12'h201), 16'hCAFE);
    do_reset(1);
    rd_lit(1'b1, ASZ'(12'h201), 16'h0000, "abort_rd16");

    // Randomized traffic, including requests while busy.
    for (int c = 0; c < 1500; c++) begin
      req = ($urandom_range(0, 3) != 0);
      we  = $urandom_range(0, 1) == 1;
      sz  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) ai = ASZ'(SIZE - 1 - $urandom_range(0, 3));
      else ai = ASZ'($urandom_range(0, 15));
      vi = 16'($urandom);
      @(posedge clk); #1;
    end
    req = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spram16_ctl.md
Name: spram16_ctl

Overview:
Parametrised successor to the 8-bit single-port RAM. It is a byte-addressed, little-endian memory controller over a 16-bit-wide single-port word array, the organisation of the UP5K SPRAM.
- Supports 8-bit and 16-bit accesses, including unaligned 16-bit accesses, which are split into two word cycles.
- Uses a req/ack handshake.
- Optionally zero-fills the array after reset.
- Sits between the eForth core's memory bus and the SPRAM macros.

Parameters:
ASZ, 17, byte address width (2^ASZ bytes; word array depth 2^(ASZ-1) x 16)
CLR_ON_RST, 1, 1 = zero-fill whole array after reset; 0 = skip fill

Ports:
clk   input   1      system clock; all state changes on rising edge
rst   input   1      synchronous reset, active-low (sampled on clk rising edge)
req   input   1      access request, sampled only while busy=0
we    input   1      1 = write, 0 = read; qualified by req
sz    input   1      0 = byte access, 1 = 16-bit access
ai    input   ASZ    byte address
vi    input   16     write data; byte access uses vi[7:0]
vo    output  16     read data; valid in the ack cycle, held until the next read ack
ack   output  1      one-cycle completion pulse per accepted request
busy  output  1      1 = request will not be accepted this cycle

Behaviour:
- Storage mapping: byte address a maps to word a>>1. Lane a[0]=0 is bits[7:0]; lane a[0]=1 is bits[15:8]. Writes use a per-lane byte mask.
- Reset: rst=0 at an edge gives ack=0 and vo=0.
  - CLR_ON_RST=1: busy=1, state CLR, clear counter=0.
  - CLR_ON_RST=0: state IDLE, busy=0 once rst=1.
- State CLR: each cycle writes 0x0000 to word[cnt] and increments cnt. After word 2^(ASZ-1)-1 is written, go to IDLE with busy=0 on the next edge. Fill takes exactly 2^(ASZ-1) cycles after rst returns high. req is ignored throughout.
- State IDLE, req=1, access is a byte or an aligned 16-bit (ai[0]=0):
  - Perform the whole access at this edge.
  - ack=1 for the following cycle.
  - Stay in IDLE with busy=0.
  - Back-to-back requests give one ack per cycle, each delayed one cycle.
- State IDLE, req=1, access is an unaligned 16-bit (sz=1, ai[0]=1):
  - Latch we/ai/vi.
  - At this edge, access lane 1 of word ai>>1 (write vi[7:0], or capture the low read byte).
  - Go to SPLIT with busy=1.
- State SPLIT:
  - Access lane 0 of word ((ai+1) mod 2^ASZ)>>1 (write latched vi[15:8], or capture the high read byte).
  - Assert ack=1, return to IDLE, busy=0.
  - Total latency: ack 2 cycles after acceptance.
  - req is ignored while in SPLIT; the master must hold off or re-issue.
- Read data format:
  - Byte read: vo={8'h00, byte[ai]}.
  - 16-bit read: vo={byte[ai+1], byte[ai]}.
  - vo is updated only on read completion; writes leave vo unchanged.
- Wrap-around: byte address 2^ASZ-1 plus 1 wraps to 0.
  - An unaligned 16-bit access at the top byte touches the top byte and byte 0.
  - Aligned accesses never cross a word.
- Write collision: write then read of the same address in consecutive cycles returns the new data. Writes complete at the accepting edge, so there is no hazard.
- Reset mid-operation: rst=0 in SPLIT or CLR aborts the access.
  - The second half of a split write is not performed; the first half may remain, but is overwritten if the fill runs.
  - No ack is issued for the aborted request.
  - The controller restarts per reset rules.
- Outputs are registered: ack, busy and vo come from flops, with no combinational path from req.

Test Plan:
1. Fill: preload word 0x0FFFF=0xDEAD, pulse rst=0 one cycle (CLR_ON_RST=1) -> busy=1 for 65536 cycles then 0; 16-bit read 0x1FFFE -> vo=0x0000, ack one cycle after req.
2. Byte lanes: byte write 0x00005<-0xA5, byte write 0x00004<-0x3C, 16-bit read 0x00004 -> vo=0xA53C; byte read 0x00005 -> vo=0x00A5.
3. Unaligned split: 16-bit write 0x00101<-0xBEEF -> busy=1 one cycle, ack 2 cycles after req. Then byte reads give 0x00101=0x00EF, 0x00102=0x00BE, and 0x00100, 0x00103 unchanged (0x0000); 16-bit read 0x00101 -> 0xBEEF.
4. Wrap: 16-bit write 0x1FFFF<-0x1234 -> byte read 0x1FFFF=0x0034, byte read 0x00000=0x0012; 16-bit read 0x1FFFF -> 0x1234.
5. Back-to-back: req held 4 cycles, aligned writes 0x0,0x2,0x4,0x6 <- 0x1111..0x4444 -> 4 consecutive acks, busy stays 0; reads return the same values. Also: req asserted during SPLIT -> ignored, no extra ack.
6. Reset abort: rst=0 during the SPLIT cycle of an unaligned write to 0x00201 -> no ack, busy=1, fill runs; afterwards 16-bit read 0x00201 -> 0x0000.
